// File: rtl/regs_arbiter.sv
// regs_arbiter: round-robin sharing of the single regs bank access port
// between NUM_REQ requesters, one outstanding transaction at a time, with a
// bounded wait for the bank acknowledge (timeout completes with an error).
module regs_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_SIZE_P = 4,
  parameter int TIMEOUT_P   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_rd_wr,
  input  logic [NUM_REQ*ADDR_SIZE_P-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0]          req_write_val,
  output logic [NUM_REQ-1:0]             ack,
  output logic [31:0]                    rsp_read_val,
  output logic                           rsp_err,
  output logic                           bus_req,
  output logic                           bus_rd_wr,
  output logic [ADDR_SIZE_P-1:0]         bus_addr,
  output logic [31:0]                    bus_write_val,
  input  logic [31:0]                    bus_read_val,
  input  logic                           bus_ack,
  output logic                           busy,
  output logic [7:0]                     timeout_cnt
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_P);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_P - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [GW-1:0]          last_grant;
  logic [GW-1:0]          grant;
  logic [TW-1:0]          timer;
  logic [GW-1:0]          cand;
  logic [GW-1:0]          pick;
  logic                   pick_valid;
  logic                   sel_rd_wr;
  logic [ADDR_SIZE_P-1:0] sel_addr;
  logic [31:0]            sel_write_val;

  // Round-robin search starting one past the last served requester.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((32'(last_grant) + i) % NUM_REQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  // Command fields of the requester that would be granted this cycle.
  always_comb begin
    sel_rd_wr     = req_rd_wr[pick];
    sel_addr      = req_addr[pick*ADDR_SIZE_P +: ADDR_SIZE_P];
    sel_write_val = req_write_val[pick*32 +: 32];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; an acknowledge beats a coincident timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (bus_ack || (timer == TIMER_LAST)) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    ack     = '0;
    bus_req = (state == ISSUE);
    busy    = (state != IDLE);
    if (state == RESP) begin
      ack[grant] = 1'b1;
    end
  end

  // Grant/command latch, wait timer, response capture and timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant    <= GW'(NUM_REQ - 1);
      grant         <= '0;
      timer         <= '0;
      timeout_cnt   <= '0;
      rsp_read_val  <= '0;
      rsp_err       <= 1'b0;
      bus_rd_wr     <= 1'b0;
      bus_addr      <= '0;
      bus_write_val <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant         <= pick;
            bus_rd_wr     <= sel_rd_wr;
            bus_addr      <= sel_addr;
            bus_write_val <= sel_write_val;
          end
        end
        ISSUE: begin
          timer <= '0;
        end
        WAIT: begin
          if (bus_ack) begin
            rsp_read_val <= bus_rd_wr ? 32'h0000_0000 : bus_read_val;
            rsp_err      <= 1'b0;
          end else if (timer == TIMER_LAST) begin
            rsp_read_val <= 32'hDEAD_BEEF;
            rsp_err      <= 1'b1;
            if (timeout_cnt != 8'hFF) begin
              timeout_cnt <= timeout_cnt + 8'd1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          last_grant <= grant;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/regs_arbiter.md
Name: regs_arbiter

Overview:
- Shares the single register-bank access port (addr/rd_wr/req/write_val -> read_val/ack) between NUM_REQ independent requesters, e.g. a CPU bridge and a debug port.
- Round-robin arbitration; exactly one transaction outstanding on the bank at a time.
- Bounded response wait: a transaction the bank does not acknowledge within TIMEOUT_P cycles is completed with an error.
- Sits between requester logic and the regs bank instance.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_SIZE_P, 4, register address width, matches the regs bank
TIMEOUT_P, 8, cycles in WAIT without bus_ack before timeout (>=2)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester request, level, held until own ack
req_rd_wr  input  NUM_REQ  per-requester direction, 1=write, 0=read
req_addr  input  NUM_REQ*ADDR_SIZE_P  per-requester address, requester i at slice i
req_write_val  input  NUM_REQ*32  per-requester write data, slice i
ack  output  NUM_REQ  one-cycle completion pulse to the granted requester
rsp_read_val  output  32  read data, valid only while any ack bit is high
rsp_err  output  1  timeout flag, valid only while any ack bit is high
bus_req  output  1  one-cycle request pulse to the regs bank
bus_rd_wr  output  1  latched direction
bus_addr  output  ADDR_SIZE_P  latched address
bus_write_val  output  32  latched write data
bus_read_val  input  32  bank read data, valid with bus_ack
bus_ack  input  1  bank completion
busy  output  1  state != IDLE
timeout_cnt  output  8  saturating count of timed-out transactions

Behaviour:
- Reset: state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), timer=0, timeout_cnt=0. All outputs low/zero: ack, bus_req, bus_*, rsp_*, busy.
- Reset has priority over everything. Reset mid-transaction aborts it: no ack is issued, and any later bus_ack is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered or decoded from registered state.
- IDLE: if any req bit is set, grant the first requester with req=1 searching last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - Latch that requester's rd_wr/addr/write_val into bus_*.
  - Store grant index; go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE: bus_req=1 for exactly this one cycle; timer=0; go to WAIT.
- WAIT, checked in this order:
  - bus_ack=1: capture bus_read_val into rsp_read_val (write transactions capture 0), rsp_err=0; go to RESP.
  - else timer==TIMEOUT_P-1: rsp_read_val=32'hDEAD_BEEF, rsp_err=1, timeout_cnt+1 saturating at 255; go to RESP.
  - else timer+1.
- RESP: ack[grant]=1 for one cycle; last_grant=grant; go to IDLE.
- bus_ack in the same WAIT cycle as timer==TIMEOUT_P-1 counts as success (ack wins).
- bus_ack outside WAIT is ignored.
- Latency with a bank that acks the cycle after bus_req:
  - req sampled in IDLE at edge 0.
  - bus_req high in cycle 1.
  - bus_ack in cycle 2.
  - ack high in cycle 3.
  - Minimum 3 cycles req->ack; back-to-back throughput 1 transaction per 4 cycles.
- Requester rules:
  - Hold req and command stable until ack is seen.
  - Drop req, or change the command, in the cycle after ack. IDLE then samples the new value and the same requester is not re-granted spuriously.
- Requester dropping req before its ack (protocol violation): the transaction still completes and ack still pulses.
- Requests arriving while busy wait in IDLE arbitration. They are never lost, never acked early, and no requester starves.
- bus_* hold their latched values after completion until the next grant.
- rsp_read_val and rsp_err hold their values after ack, but are defined only while ack is high.

Test Plan:
- Reset held 3 cycles, then released with no req -> all outputs 0, busy=0, bus_req never pulses.
- Requester 0 reads addr 1, bank returns 32'h0000_0005 one cycle after bus_req -> bus_req pulse in cycle 1 with bus_addr=1, bus_rd_wr=0; ack=2'b01 in cycle 3 with rsp_read_val=5, rsp_err=0.
- Both requesters hold req continuously, each doing 4 writes -> grant order 0,1,0,1,... with acks alternating 2'b01/2'b10; 8 bus_req pulses, each carrying the granted requester's addr/data.
- Bank never acks, TIMEOUT_P=8 -> ack pulses exactly 8 cycles after the WAIT entry cycle with rsp_err=1, rsp_read_val=32'hDEAD_BEEF; timeout_cnt=1. A following normal read succeeds.
- bus_ack arrives in the same cycle timer reaches TIMEOUT_P-1 -> rsp_err=0, data captured, timeout_cnt unchanged.
- Reset asserted in WAIT, then bus_ack the next cycle -> no ack pulse, state IDLE, timeout_cnt=0, busy=0.
